// File: rtl/cpu_pkg.sv
// Shared CPU definitions: addressing-mode codes, fetch FSM states, argument decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [2:0] MODE_REG    = 3'h0;
    localparam logic [2:0] MODE_REGIND = 3'h1;
    localparam logic [2:0] MODE_IMM    = 3'h2;
    localparam logic [2:0] MODE_DIR    = 3'h4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAPTURE,
        ST_FAULT
    } fetch_state_t;

    // Instructions in IMM or DIR mode are followed by a 32-bit argument word.
    function automatic logic has_arg(input logic [2:0] mode);
        return (mode == MODE_IMM) || (mode == MODE_DIR);
    endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Fetcher signal bundle: shared-bus read port plus the instruction port to control.
// Latency: n/a (wires only).
// Backpressure: bus_wait stalls the fetcher; ir_pop consumes the head instruction.
interface fetch_prefetch_if #(
    parameter int AW = 32
);
    logic [AW-1:0] bus_addr;
    logic          bus_read;
    logic [3:0]    byteenable;
    logic          bus_wait;
    logic [31:0]   bus_data_in;
    logic [31:0]   ir;
    logic [31:0]   arg;
    logic          ir_has_arg;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_pop;
    logic          flush;
    logic [AW-1:0] flush_addr;
    logic          fault;

    modport master (
        output bus_addr, bus_read, byteenable, ir, arg, ir_has_arg, ir_pc, ir_valid, fault,
        input  bus_wait, bus_data_in, ir_pop, flush, flush_addr
    );

    modport slave (
        input  bus_addr, bus_read, byteenable, ir, arg, ir_has_arg, ir_pc, ir_valid, fault,
        output bus_wait, bus_data_in, ir_pop, flush, flush_addr
    );
endinterface

// File: rtl/prefetch_ring.sv
// Prefetch ring: DEPTH entries of {word, pc} with head/tail pointers and occupancy count.
// Latency: a push is visible at the read ports the cycle after it is written.
// Backpressure: none internally; the caller never pushes into a full ring.
module prefetch_ring #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [31:0]              push_dat,
    input  logic [AW-1:0]            push_pc,
    input  logic                     pop1,
    input  logic                     pop2,
    input  logic                     clear,
    output logic [31:0]              head_dat,
    output logic [AW-1:0]            head_pc,
    output logic [31:0]              next_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   dat_q [DEPTH];
    logic [31:0]   dat_d [DEPTH];
    logic [AW-1:0] pc_q  [DEPTH];
    logic [AW-1:0] pc_d  [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Next ring state: clear wins over everything; push and pop otherwise combine in one cycle.
    always_comb begin
        dat_d   = dat_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) begin
                dat_d[tail_q] = push_dat;
                pc_d[tail_q]  = push_pc;
                tail_d        = tail_q + PW'(1);
            end
            count_d = count_q + CW'(push) - (pop2 ? CW'(2) : CW'(pop1));
            head_d  = head_q + (pop2 ? PW'(2) : PW'(pop1));
        end
    end

    // Ring storage and pointers; storage is zeroed so the head reads 0 out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
                pc_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            dat_q   <= dat_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_dat = dat_q[head_q];
    assign head_pc  = pc_q[head_q];
    assign next_dat = dat_q[head_q + PW'(1)];
    assign count    = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Free-running instruction fetcher: fills a prefetch ring and presents whole instructions.
// Latency: 2 cycles per word (REQ, CAPTURE); ir_valid 3 cycles after reset release.
// Backpressure: bus_wait holds REQ (faults after WAIT_LIMIT); a full ring parks in IDLE.
module fetch_prefetch
    import cpu_pkg::*;
#(
    parameter int            AW         = 32,
    parameter int            DEPTH      = 4,
    parameter logic [AW-1:0] RESET_PC   = '0,
    parameter int            WAIT_LIMIT = 255
) (
    input logic               clock,
    input logic               reset_n,
    fetch_prefetch_if.master  fif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          fault_q, fault_d;

    logic          push, clear, pop1, pop2;
    logic [31:0]   head_dat, next_dat;
    logic [AW-1:0] head_pc;
    logic [CW-1:0] count, pop_n, count_after;
    logic          head_has_arg, head_vld, pop_ok;

    prefetch_ring #(.AW(AW), .DEPTH(DEPTH)) u_ring (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (fif.bus_data_in),
        .push_pc  (fetch_pc_q),
        .pop1     (pop1),
        .pop2     (pop2),
        .clear    (clear),
        .head_dat (head_dat),
        .head_pc  (head_pc),
        .next_dat (next_dat),
        .count    (count)
    );

    // Head decode: a two-word instruction is only complete once its argument is buffered.
    always_comb begin
        head_has_arg = has_arg(head_dat[31:29]);
        head_vld     = (count != '0) && (!head_has_arg || (count >= CW'(2)));
        pop_ok       = fif.ir_pop && head_vld && !fif.flush;
        pop2         = pop_ok && head_has_arg;
        pop1         = pop_ok && !head_has_arg;
        pop_n        = pop2 ? CW'(2) : CW'(pop1);
        count_after  = count + CW'(1) - pop_n;
    end

    // Fetch FSM next state; a flush overrides whatever the current state decided.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;
        push       = 1'b0;
        clear      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fault_q && (count < DEPTH_C)) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!fif.bus_wait) begin
                    state_d    = ST_CAPTURE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == 8'(WAIT_LIMIT)) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                push       = 1'b1;
                fetch_pc_d = fetch_pc_q + AW'(4);
                state_d    = (count_after < DEPTH_C) ? ST_REQ : ST_IDLE;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (fif.flush) begin
            clear      = 1'b1;
            push       = 1'b0;
            fetch_pc_d = fif.flush_addr;
            wait_cnt_d = '0;
            if (fif.flush_addr[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = ST_FAULT;
            end else if (state_q == ST_FAULT) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    // Fetch FSM registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign fif.bus_read   = (state_q == ST_REQ) || (state_q == ST_CAPTURE);
    assign fif.bus_addr   = fetch_pc_q;
    assign fif.byteenable = 4'b1111;
    assign fif.ir         = head_dat;
    assign fif.arg        = head_has_arg ? next_dat : 32'h0;
    assign fif.ir_has_arg = head_has_arg;
    assign fif.ir_pc      = head_pc;
    assign fif.ir_valid   = head_vld;
    assign fif.fault      = fault_q;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed boundary scenarios plus a randomized run
// checked against an instruction-stream model (memory walk from the fetch start).
module tb_fetch_prefetch;
    localparam int AW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] mem [256];

    fetch_prefetch_if #(.AW(AW)) fif ();

    fetch_prefetch #(
        .AW(AW), .DEPTH(4), .RESET_PC(32'h0), .WAIT_LIMIT(255)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .fif     (fif)
    );

    always #5 clk = ~clk;

    // Memory answers whatever address is on the bus.
    assign fif.bus_data_in = mem[fif.bus_addr[9:2]];

    int          busy, n, stall;
    logic [31:0] last_addr, exp_pc, exp_ir, exp_arg, drv_faddr;
    logic        exp_has, prev8, cur8, found, drv_pop, drv_flush, drv_vld;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_valid(input int limit, input string name);
        int k;
        k = 0;
        while (fif.ir_valid !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (fif.ir_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s: ir_valid still 0 after %0d cycles", name, limit);
        end
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        fif.bus_wait    = 1'b0;
        fif.ir_pop      = 1'b0;
        fif.flush       = 1'b0;
        fif.flush_addr  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic is_two_word(input logic [31:0] w);
        return (w[31:29] == 3'b010) || (w[31:29] == 3'b100);
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0000;
        mem[1] = 32'h4000_0000;
        mem[2] = 32'h1234_5678;

        // Reset values while reset is held
        rst_n = 1'b0;
        fif.bus_wait = 1'b0; fif.ir_pop = 1'b0; fif.flush = 1'b0; fif.flush_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_bus_read", fif.bus_read, 0);
        check("rst_bus_addr", fif.bus_addr, 0);
        check("rst_ir_valid", fif.ir_valid, 0);
        check("rst_ir", fif.ir, 0);
        check("rst_arg", fif.arg, 0);
        check("rst_ir_pc", fif.ir_pc, 0);
        check("rst_fault", fif.fault, 0);
        check("byteenable", fif.byteenable, 4'hF);

        // Cold start: first REQ in cycle 1, ir_valid in cycle 3
        rst_n = 1'b1;
        @(negedge clk);
        check("cold_req_c1", {fif.bus_read, fif.bus_addr}, {1'b1, 32'h0});
        @(negedge clk);
        check("cold_invalid_c2", fif.ir_valid, 0);
        @(negedge clk);
        check("cold_valid_c3", {fif.ir_valid, fif.ir, fif.ir_pc}, {1'b1, 32'h0, 32'h0});
        fif.ir_pop = 1'b1;
        @(negedge clk);
        fif.ir_pop = 1'b0;
        wait_valid(20, "cold_imm_valid");
        check("cold_imm_ir", fif.ir, 32'h4000_0000);
        check("cold_imm_arg", {fif.ir_has_arg, fif.arg}, {1'b1, 32'h1234_5678});
        check("cold_imm_pc", fif.ir_pc, 4);

        // Fill without pops: four words then idle; one pop buys exactly one fetch at 16
        for (int i = 0; i < 8; i++) mem[i] = $urandom & 32'h1FFF_FFFF;
        do_reset();
        busy = 0; last_addr = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fif.bus_read) begin busy++; last_addr = fif.bus_addr; end
        end
        check("fill_bus_cycles", busy, 8);
        check("fill_last_addr", last_addr, 12);
        check("fill_idle", fif.bus_read, 0);
        check("fill_head", {fif.ir_valid, fif.ir}, {1'b1, mem[0]});
        fif.ir_pop = 1'b1;
        @(negedge clk);
        fif.ir_pop = 1'b0;
        busy = 0; last_addr = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fif.bus_read) begin busy++; last_addr = fif.bus_addr; end
        end
        check("refill_bus_cycles", busy, 2);
        check("refill_addr", last_addr, 16);
        check("refill_head", {fif.ir_pc, fif.ir}, {32'd4, mem[1]});

        // Flush to 0x100 during CAPTURE of address 8
        mem[64] = 32'h0BAD_F00D;
        do_reset();
        prev8 = 1'b0; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            cur8 = fif.bus_read && (fif.bus_addr == 32'h8);
            if (prev8 && cur8) found = 1'b1;
            prev8 = cur8;
        end
        check("flush_found_capture", found, 1);
        fif.flush = 1'b1; fif.flush_addr = 32'h100;
        @(negedge clk);
        fif.flush = 1'b0;
        check("flush_redirect", {fif.bus_read, fif.bus_addr}, {1'b1, 32'h100});
        check("flush_cleared", fif.ir_valid, 0);
        @(negedge clk);
        check("flush_wait_capture", fif.ir_valid, 0);
        @(negedge clk);
        check("flush_new_head", {fif.ir_valid, fif.ir_pc, fif.ir}, {1'b1, 32'h100, 32'h0BAD_F00D});

        // Two-word instruction at the tail, then pop-2 wrapping past the ring end
        mem[3] = 32'h4000_0ABC;
        mem[4] = 32'hCAFE_0004;
        mem[5] = 32'h0000_5555;
        do_reset();
        repeat (20) @(negedge clk);
        check("wrap_full_idle", fif.bus_read, 0);
        fif.ir_pop = 1'b1;
        repeat (3) @(negedge clk);
        fif.ir_pop = 1'b0;
        check("wrap_arg_pending", {fif.ir_valid, fif.ir_has_arg, fif.ir_pc}, {1'b0, 1'b1, 32'd12});
        wait_valid(10, "wrap_imm_valid");
        check("wrap_imm", {fif.ir_pc, fif.ir}, {32'd12, 32'h4000_0ABC});
        check("wrap_imm_arg", fif.arg, 32'hCAFE_0004);
        fif.ir_pop = 1'b1;
        @(negedge clk);
        fif.ir_pop = 1'b0;
        wait_valid(20, "wrap_after_pop2");
        check("wrap_after_pop2", {fif.ir_pc, fif.ir}, {32'd20, 32'h0000_5555});
        check("wrap_single_arg", {fif.ir_has_arg, fif.arg}, {1'b0, 32'h0});

        // Bus timeout: 255 stalled REQ cycles then a sticky fault
        do_reset();
        fif.bus_wait = 1'b1;
        busy = 0;
        for (int i = 0; i < 400 && !fif.fault; i++) begin
            @(negedge clk);
            if (fif.bus_read) busy++;
        end
        check("wait_fault", fif.fault, 1);
        check("wait_cycles", busy, 255);
        check("wait_bus_idle", fif.bus_read, 0);
        fif.bus_wait = 1'b0;
        fif.flush = 1'b1; fif.flush_addr = 32'h40;
        @(negedge clk);
        fif.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("fault_sticky_flush", {fif.fault, fif.bus_read}, {1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        check("fault_cleared_reset", fif.fault, 0);

        // Misaligned flush target faults immediately
        do_reset();
        repeat (5) @(negedge clk);
        fif.flush = 1'b1; fif.flush_addr = 32'h102;
        @(negedge clk);
        fif.flush = 1'b0;
        check("misaligned_fault", {fif.fault, fif.bus_read}, {1'b1, 1'b0});

        // Randomized run against the instruction-stream model
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        do_reset();
        exp_pc = 32'h0;
        drv_pop = 1'b0; drv_flush = 1'b0; drv_vld = 1'b0; drv_faddr = '0;
        stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (drv_flush) exp_pc = drv_faddr;
            else if (drv_pop && drv_vld) exp_pc = exp_pc + (is_two_word(mem[exp_pc[9:2]]) ? 32'd8 : 32'd4);
            exp_ir  = mem[exp_pc[9:2]];
            exp_has = is_two_word(exp_ir);
            exp_arg = exp_has ? mem[exp_pc[9:2] + 8'd1] : 32'h0;
            if (fif.ir_valid) begin
                stall = 0;
                check("rand_ir", {fif.ir_pc, fif.ir}, {exp_pc, exp_ir});
                check("rand_arg", {31'h0, fif.ir_has_arg, fif.arg}, {31'h0, exp_has, exp_arg});
            end else begin
                stall++;
                if (stall == 300) begin
                    checks++; failures++;
                    $display("FAIL rand_liveness: ir_valid low for 300 cycles, expected progress");
                end
            end
            drv_vld   = fif.ir_valid;
            drv_pop   = ($urandom_range(0, 1) == 1);
            drv_flush = ($urandom_range(0, 99) == 0);
            drv_faddr = 32'($urandom_range(0, 255)) << 2;
            fif.bus_wait   = ($urandom_range(0, 9) < 3);
            fif.ir_pop     = drv_pop;
            fif.flush      = drv_flush;
            fif.flush_addr = drv_faddr;
        end
        check("rand_no_fault", fif.fault, 0);

        // Asynchronous reset during an active bus read drops bus_read at once
        fif.ir_pop = 1'b0; fif.flush = 1'b0; fif.bus_wait = 1'b1;
        n = 0;
        while (!fif.bus_read && n < 50) begin @(negedge clk); n++; end
        check("async_pre_read", fif.bus_read, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", {fif.bus_read, fif.ir_valid}, {1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised instruction-fetch front end for the bexkat1 CPU. It replaces the inline FETCHIR/FETCHARG sequencing of the control FSM with a free-running fetcher. The fetcher fills a DEPTH-word prefetch ring over the shared bus handshake, pairs two-word instructions with their argument word, and presents one complete instruction at a time to the control unit. It also supports redirect (flush) and detects bus timeouts.

## Interface
Parameters:
- AW, 32: bus address width.
- DEPTH, 4: prefetch ring depth in 32-bit words; power of two, ≥2.
- RESET_PC, 0: fetch address after reset.
- WAIT_LIMIT, 255: consecutive bus_wait-high cycles in REQ before a fault; 8-bit counter.

Ports:
- clock, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- bus_addr, out, AW: fetch address; valid while bus_read=1.
- bus_read, out, 1: bus read request.
- byteenable, out, 4: constant 4'b1111.
- bus_wait, in, 1: high = bus not granted.
- bus_data_in, in, 32: read data.
- ir, out, 32: head instruction word.
- arg, out, 32: argument word; 0 when ir_has_arg=0.
- ir_has_arg, out, 1: ir mode is IMM (3'h2) or DIR (3'h4).
- ir_pc, out, AW: address of ir.
- ir_valid, out, 1: ir (and arg if needed) complete.
- ir_pop, in, 1: consume head; ignored when ir_valid=0.
- flush, in, 1: redirect fetch.
- flush_addr, in, AW: new fetch address.
- fault, out, 1: sticky fetch fault.

## Operation
- FSM states:
  - IDLE: bus_read=0.
    - Go to REQ when count<DEPTH and fault=0.
  - REQ: bus_read=1, bus_addr=fetch_pc.
    - bus_wait=0 → go to CAPTURE, clear the wait counter.
    - Otherwise increment the wait counter. When it reaches WAIT_LIMIT → go to FAULT.
  - CAPTURE: bus_read=1 held.
    - Write bus_data_in into the ring at the tail, together with its pc.
    - fetch_pc += 4, count += 1.
    - Go to REQ if count+1<DEPTH after this cycle's pop, else go to IDLE.
  - FAULT: bus_read=0; fault=1 until reset; ring contents still drain to the consumer.
- Head decode:
  - ir_has_arg = ir[31:29] ∈ {3'h2, 3'h4}.
  - ir_valid = count≥1 && (!ir_has_arg || count≥2).
  - arg = ring[head+1].
- ir_pop with ir_valid: head advances by 1 or 2 (2 when ir_has_arg); count decreases by the same amount.
- Simultaneous CAPTURE write and pop: the net count update is applied in the same cycle; count never exceeds DEPTH.
- Head and tail pointers wrap modulo DEPTH.
- Flush (highest priority):
  - Ring cleared: count=0, head=tail.
  - fetch_pc ← flush_addr; wait counter cleared.
  - In REQ: go to REQ next cycle at the new address.
  - In CAPTURE: the data is discarded and the FSM goes to REQ.
  - A flush in the same cycle as ir_pop wins; the pop is ignored.
- flush_addr[1:0]≠0: fault=1 and the FSM goes to FAULT.
- Flush does not clear a fault.

## Timing
- Reset values:
  - bus_read=0, bus_addr=RESET_PC, ir_valid=0, ir=0, arg=0, ir_pc=0, fault=0.
  - FSM in IDLE, count=0, fetch_pc=RESET_PC.
- The first REQ occurs in the first cycle after reset deassertion.
- With bus_wait=0, each word takes 2 cycles (REQ, CAPTURE). Peak rate is one word per 2 cycles.
- ir_valid rises in the cycle after the CAPTURE that completes the instruction. Minimum fill-to-valid is 3 cycles from the first REQ.
- All outputs are registered or decoded from registers; there is no combinational path from ir_pop to bus_read.
- Reset assertion mid-transaction: all state is cleared immediately and bus_read drops asynchronously.

## Structure
- cpu_pkg holds:
  - MODE_REG, MODE_REGIND, MODE_IMM, MODE_DIR constants.
  - The fetch FSM state enum (IDLE, REQ, CAPTURE, FAULT).
  - A has_arg(mode) function, shared with control.
- One sub-module, prefetch_ring:
  - DEPTH×(32+AW) storage with head and tail pointers and a count.
  - Ports for push, pop-1/pop-2 and clear.
  - Read ports for head and head+1.

## Test plan
- Cold start, bus_wait=0, RESET_PC=0, memory {0x00000000, 0x40000000, 0x12345678}:
  - ir=0x0 with ir_valid in cycle 3.
  - The next ir is 0x40000000 (IMM) with arg=0x12345678 and ir_pc=4.
- No pops, DEPTH=4:
  - Exactly 4 CAPTUREs, then IDLE with bus_read=0.
  - One single-word pop → exactly one more fetch, at address 16.
- Hold bus_wait=1 for 255 cycles in REQ → fault=1 and bus_read=0. fault persists after flush and clears only on reset_n=0.
- flush_addr=0x100 asserted during CAPTURE of address 8:
  - The word is discarded; the next bus_addr is 0x100.
  - ir_valid=0 until 0x100 is captured.
- Two-word instruction at the tail with only one word buffered → ir_valid stays 0 until the arg word is captured. Pop then advances head by 2 and wraps correctly at DEPTH.
